// File: rtl/pixel_stream_transmitter_pkg.sv
// Shared definitions for the pixel stream transmitter and the input layer it feeds.
package pixel_stream_transmitter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int PIXEL_COUNT_DEFAULT = 784;
    localparam int WORD_WIDTH_DEFAULT  = 16;
    localparam int INDEX_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        WAIT_READY = 2'd1,
        STREAM     = 2'd2,
        GAP        = 2'd3
    } txState_t;

    function automatic int ceilDiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/pixel_image_buffer.sv
// Word-addressed image store with a single-bit read port indexed by pixel number.
module pixel_image_buffer #(
    parameter int WORD_COUNT  = 49,
    parameter int WORD_WIDTH  = 16,
    parameter int INDEX_WIDTH = 10,
    parameter int ADDR_WIDTH  = $clog2(WORD_COUNT)
) (
    input  logic                   clk,
    input  logic                   writeEnable,
    input  logic [ADDR_WIDTH-1:0]  writeAddr,
    input  logic [WORD_WIDTH-1:0]  writeData,
    input  logic [INDEX_WIDTH-1:0] readIndex,
    output logic                   readBit
);
    localparam int BIT_WIDTH = $clog2(WORD_WIDTH);

    logic [WORD_WIDTH-1:0] mem [WORD_COUNT];
    logic [ADDR_WIDTH-1:0] readWord;
    logic [BIT_WIDTH-1:0]  readSel;

    // NOTE: storage has no reset; every word is rewritten before it is read,
    // and leaving it out keeps the array out of the reset tree.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[writeAddr] <= writeData;
        end
    end

    // Pixel i lives in word i/WORD_WIDTH, bit i%WORD_WIDTH (power-of-two word width).
    assign readWord = ADDR_WIDTH'(readIndex >> BIT_WIDTH);
    assign readSel  = readIndex[BIT_WIDTH-1:0];
    assign readBit  = mem[readWord][readSel];

endmodule

// File: rtl/pixel_stream_transmitter.sv
// Loads one packed image over valid/ready, then serializes it one pixel per cycle to the input layer.
module pixel_stream_transmitter
    import pixel_stream_transmitter_pkg::*;
#(
    parameter int PIXEL_COUNT = PIXEL_COUNT_DEFAULT,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
    parameter int INDEX_WIDTH = INDEX_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_WIDTH-1:0]  wordIn,
    input  logic                   wordValid,
    output logic                   wordReady,
    input  logic                   readyForInputs,
    output logic                   inputsInbound,
    output logic                   pixelValue,
    output logic [INDEX_WIDTH-1:0] pixelIndex,
    output logic                   imageSent,
    output logic                   busy
);
    localparam int WORD_COUNT = ceilDiv(PIXEL_COUNT, WORD_WIDTH);
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT);

    txState_t state, nextState;

    logic [ADDR_WIDTH-1:0]  wordCount, wordCountNext;
    logic [INDEX_WIDTH-1:0] pixelIndexNext;
    logic wordReadyNext, inboundNext, pixelValueNext, imageSentNext, busyNext;
    logic transfer, bufferBit;

    assign transfer = wordValid && wordReady;

    pixel_image_buffer #(
        .WORD_COUNT (WORD_COUNT),
        .WORD_WIDTH (WORD_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) imageBuffer (
        .clk        (clk),
        .writeEnable(transfer),
        .writeAddr  (wordCount),
        .writeData  (wordIn),
        .readIndex  (pixelIndexNext),
        .readBit    (bufferBit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: each combinational output gets a default first so no path infers a latch.
    always_comb begin
        nextState = state;
        case (state)
            LOAD:       if (transfer && wordCount == ADDR_WIDTH'(WORD_COUNT - 1)) nextState = WAIT_READY;
            WAIT_READY: if (readyForInputs) nextState = STREAM;
            STREAM:     if (pixelIndex == INDEX_WIDTH'(PIXEL_COUNT - 1)) nextState = GAP;
            GAP:        nextState = LOAD;
            default:    nextState = LOAD;
        endcase
    end

    // Outputs are computed from the next state and registered, so none depends combinationally on inputs.
    always_comb begin
        wordCountNext = wordCount;
        if (state == GAP) begin
            wordCountNext = '0;
        end else if (transfer) begin
            wordCountNext = wordCount + ADDR_WIDTH'(1);
        end

        pixelIndexNext = '0;
        if (state == STREAM && nextState == STREAM) begin
            pixelIndexNext = pixelIndex + INDEX_WIDTH'(1);
        end

        wordReadyNext  = (nextState == LOAD);
        inboundNext    = (nextState == STREAM);
        imageSentNext  = (nextState == GAP);
        pixelValueNext = inboundNext && bufferBit;
        busyNext       = !(nextState == LOAD && wordCountNext == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wordCount     <= '0;
            pixelIndex    <= '0;
            wordReady     <= TRUE;
            inputsInbound <= FALSE;
            pixelValue    <= FALSE;
            imageSent     <= FALSE;
            busy          <= FALSE;
        end else begin
            wordCount     <= wordCountNext;
            pixelIndex    <= pixelIndexNext;
            wordReady     <= wordReadyNext;
            inputsInbound <= inboundNext;
            pixelValue    <= pixelValueNext;
            imageSent     <= imageSentNext;
            busy          <= busyNext;
        end
    end

endmodule

// File: tb/tb_pixel_stream_transmitter.sv
// Self-checking bench: loads images, streams them, compares every pixel to a word/bit reference model.
module tb_pixel_stream_transmitter;

    localparam int PIXEL_COUNT = 784;
    localparam int WORD_WIDTH  = 16;
    localparam int INDEX_WIDTH = 10;
    localparam int WORD_COUNT  = 49;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [WORD_WIDTH-1:0]  wordIn = '0;
    logic                   wordValid = 1'b0;
    logic                   wordReady;
    logic                   readyForInputs = 1'b0;
    logic                   inputsInbound;
    logic                   pixelValue;
    logic [INDEX_WIDTH-1:0] pixelIndex;
    logic                   imageSent;
    logic                   busy;

    int vectors = 0;
    int miscompares = 0;

    logic [WORD_WIDTH-1:0] imgWords [WORD_COUNT];

    pixel_stream_transmitter #(
        .PIXEL_COUNT(PIXEL_COUNT),
        .WORD_WIDTH (WORD_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wordIn        (wordIn),
        .wordValid     (wordValid),
        .wordReady     (wordReady),
        .readyForInputs(readyForInputs),
        .inputsInbound (inputsInbound),
        .pixelValue    (pixelValue),
        .pixelIndex    (pixelIndex),
        .imageSent     (imageSent),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic modelPixel(input int i);
        logic [WORD_WIDTH-1:0] w;
        w = imgWords[i / WORD_WIDTH];
        return w[i % WORD_WIDTH];
    endfunction

    task automatic fillRandom();
        for (int w = 0; w < WORD_COUNT; w++) imgWords[w] = WORD_WIDTH'($urandom);
    endtask

    // Presents the image, asserting wordValid on every 'period'-th cycle.
    task automatic loadImage(input int period, input logic readyLevel);
        int k = 0;
        int cyc = 0;
        readyForInputs = readyLevel;
        while (k < WORD_COUNT && cyc < WORD_COUNT * period + 20) begin
            wordValid = (cyc % period == 0);
            wordIn = wordValid ? imgWords[k] : WORD_WIDTH'($urandom);
            check("wordReady in LOAD", 32'(wordReady), 32'd1);
            check("no stream during LOAD", 32'(inputsInbound), 32'd0);
            tick();
            cyc++;
            if (wordValid) begin
                k++;
                if (k < WORD_COUNT) check("busy while loading", 32'(busy), 32'd1);
            end
        end
        check("load completed", 32'(k), 32'(WORD_COUNT));
        // Words offered outside LOAD must be ignored.
        wordValid = 1'b1;
        wordIn = WORD_WIDTH'($urandom);
        check("wordReady after last word", 32'(wordReady), 32'd0);
        check("busy in WAIT_READY", 32'(busy), 32'd1);
    endtask

    task automatic streamImage(input int delay, input bit toggleReady, input int abortAt);
        for (int d = 0; d < delay; d++) begin
            readyForInputs = 1'b0;
            check("idle while not ready", 32'(inputsInbound), 32'd0);
            tick();
        end
        readyForInputs = 1'b1;
        check("WAIT_READY cycle", 32'(inputsInbound), 32'd0);
        tick();
        for (int i = 0; i < PIXEL_COUNT; i++) begin
            check("pixel", 32'({imageSent, inputsInbound, pixelIndex, pixelValue}),
                  32'({1'b0, 1'b1, INDEX_WIDTH'(i), modelPixel(i)}));
            if (i == abortAt) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                wordValid = 1'b0;
                check("reset mid-stream", 32'({inputsInbound, pixelIndex, wordReady, busy}),
                      32'({1'b0, INDEX_WIDTH'(0), 1'b1, 1'b0}));
                return;
            end
            if (toggleReady) readyForInputs = 1'($urandom);
            tick();
        end
        check("GAP", 32'({inputsInbound, pixelIndex, pixelValue, imageSent, wordReady}),
              32'({1'b0, INDEX_WIDTH'(0), 1'b0, 1'b1, 1'b0}));
        if (toggleReady) readyForInputs = 1'($urandom);
        tick();
        wordValid = 1'b0;
        check("after GAP", 32'({imageSent, wordReady, busy, inputsInbound}), 32'({1'b0, 1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("reset state", 32'({wordReady, inputsInbound, pixelIndex, busy, imageSent, pixelValue}),
              32'({1'b1, 1'b0, INDEX_WIDTH'(0), 1'b0, 1'b0, 1'b0}));

        // Full back-to-back load of 16'hA5A5 with readiness already high.
        for (int w = 0; w < WORD_COUNT; w++) imgWords[w] = 16'hA5A5;
        loadImage(1, 1'b1);
        streamImage(0, 1'b0, -1);

        // Receiver not ready for 20 cycles; readiness toggles randomly while streaming.
        fillRandom();
        loadImage(1, 1'b0);
        streamImage(20, 1'b1, -1);

        // Source stalls: one word every third cycle, single marker in the last pixel.
        for (int w = 0; w < WORD_COUNT; w++) imgWords[w] = '0;
        imgWords[WORD_COUNT - 1] = 16'h8000;
        loadImage(3, 1'b0);
        streamImage(2, 1'b1, -1);

        // Reset at pixel 300, then a complete image.
        fillRandom();
        loadImage(1, 1'b1);
        streamImage(0, 1'b1, 300);
        fillRandom();
        loadImage(2, 1'b1);
        streamImage(0, 1'b1, -1);

        // Two images back to back with readiness held high.
        fillRandom();
        loadImage(1, 1'b1);
        streamImage(0, 1'b0, -1);
        fillRandom();
        loadImage(1, 1'b1);
        streamImage(0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
